// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources from the register file and retries while they are not ready.
// It invalidates the destination on the successful check, then holds the instruction until execute accepts it.
module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             in_wr_rd,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [7:0]       in_op,
  output logic [4:0]       rf_addr_p0,
  output logic [4:0]       rf_addr_p1,
  output logic             rf_re_p0,
  output logic             rf_re_p1,
  input  logic [XLEN-1:0]  rf_dout_p0,
  input  logic [XLEN-1:0]  rf_dout_p1,
  input  logic             rf_v_p0,
  input  logic             rf_v_p1,
  input  logic             rf_source_not_ready,
  output logic             rf_we_pi,
  output logic [4:0]       rf_addr_pi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_op,
  output logic [XLEN-1:0]  out_src1,
  output logic [XLEN-1:0]  out_src2,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic             out_wr_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, READ, CHECK, ISSUE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [4:0]        rs1_reg, rs2_reg, rd_reg;
  logic              use_rs1_reg, use_rs2_reg, wr_rd_reg;
  logic [XLEN-1:0]   imm_reg;
  logic [7:0]        op_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [7:0]        out_op_reg;
  logic [XLEN-1:0]   out_src1_reg, out_src2_reg, out_imm_reg;
  logic [4:0]        out_rd_reg;
  logic              out_wr_rd_reg;
  logic              accept, check_ok;
  logic [XLEN-1:0]   src1_sel, src2_sel;

  // The per-port valid bits are carried by the register file interface but readiness
  // is summarised by rf_source_not_ready.
  logic unused_valid_bits;
  assign unused_valid_bits = rf_v_p0 ^ rf_v_p1;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    check_ok   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && !flush) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ:  state_next = CHECK;
      CHECK: begin
        if (rf_source_not_ready) begin
          state_next = READ;
        end else begin
          check_ok   = !flush && !reset;
          state_next = ISSUE;
        end
      end
      ISSUE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Register index 0 is hardwired to zero, so its read data is never trusted.
  assign src1_sel = (use_rs1_reg && rs1_reg != 5'd0) ? rf_dout_p0 : '0;
  assign src2_sel = (use_rs2_reg && rs2_reg != 5'd0) ? rf_dout_p1 : '0;

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == ISSUE);
  assign rf_re_p0   = (state_reg == READ) && use_rs1_reg;
  assign rf_re_p1   = (state_reg == READ) && use_rs2_reg;
  assign rf_addr_p0 = rf_re_p0 ? rs1_reg : 5'd0;
  assign rf_addr_p1 = rf_re_p1 ? rs2_reg : 5'd0;
  assign rf_we_pi   = check_ok && wr_rd_reg && (rd_reg != 5'd0);
  assign rf_addr_pi = rf_we_pi ? rd_reg : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      use_rs1_reg   <= 1'b0;
      use_rs2_reg   <= 1'b0;
      wr_rd_reg     <= 1'b0;
      imm_reg       <= '0;
      op_reg        <= '0;
      stall_cnt_reg <= '0;
      out_op_reg    <= '0;
      out_src1_reg  <= '0;
      out_src2_reg  <= '0;
      out_imm_reg   <= '0;
      out_rd_reg    <= '0;
      out_wr_rd_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rs1_reg     <= in_rs1;
        rs2_reg     <= in_rs2;
        rd_reg      <= in_rd;
        use_rs1_reg <= in_use_rs1;
        use_rs2_reg <= in_use_rs2;
        wr_rd_reg   <= in_wr_rd;
        imm_reg     <= in_imm;
        op_reg      <= in_op;
      end
      if (flush || accept) begin
        stall_cnt_reg <= '0;
      end else if (state_reg == CHECK && rf_source_not_ready && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if (check_ok) begin
        out_op_reg    <= op_reg;
        out_src1_reg  <= src1_sel;
        out_src2_reg  <= src2_sel;
        out_imm_reg   <= imm_reg;
        out_rd_reg    <= rd_reg;
        out_wr_rd_reg <= wr_rd_reg;
      end
    end
  end

  assign out_op    = out_op_reg;
  assign out_src1  = out_src1_reg;
  assign out_src2  = out_src2_reg;
  assign out_imm   = out_imm_reg;
  assign out_rd    = out_rd_reg;
  assign out_wr_rd = out_wr_rd_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
